// File: rtl/imm_ext_pkg.sv
// Shared types and constants for the immediate-extension pipeline.
// Mode encodings and error-counter sizing live here so every stage agrees.
package imm_ext_pkg;

  typedef enum logic [2:0] {
    IMM_ZE     = 3'd0,
    IMM_SE     = 3'd1,
    IMM_SE_SH2 = 3'd2,
    IMM_MOVW   = 3'd3
  } imm_mode_e;

  localparam int                   ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Request/response bundle of the immediate-extension pipeline.
// The slave modport is the extender's view; the master modport is the decode stage.
interface imm_ext_pipe_if
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int OUT_W = 64,
  parameter int WW    = $clog2(IN_W + 1)
);

  logic                 in_valid;
  logic                 in_ready;
  logic [IN_W-1:0]      in_imm;
  logic [WW-1:0]        in_width;
  logic [2:0]           in_mode;
  logic [1:0]           in_hw;
  logic                 out_valid;
  logic                 out_ready;
  logic [OUT_W-1:0]     out_data;
  logic                 out_err;
  logic [ERR_CNT_W-1:0] err_count;

  modport slave (
    input  in_valid, in_imm, in_width, in_mode, in_hw, out_ready,
    output in_ready, out_valid, out_data, out_err, err_count
  );

  modport master (
    output in_valid, in_imm, in_width, in_mode, in_hw, out_ready,
    input  in_ready, out_valid, out_data, out_err, err_count
  );

endinterface

// File: rtl/imm_ext_fifo2.sv
// Two-entry in-order buffer with registered head; the head holds its last
// value when drained so downstream sees stable data while idle.
module imm_ext_fifo2 #(
  parameter int W = 65
) (
  input  logic         clk,
  input  logic         clr_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);

  logic [1:0]   count_r;
  logic [W-1:0] head_r;
  logic [W-1:0] tail_r;
  logic         push_ok_s;
  logic         pop_ok_s;

  assign full      = (count_r == 2'd2);
  assign empty     = (count_r == 2'd0);
  assign push_ok_s = push & ~full;
  assign pop_ok_s  = pop & ~empty;
  assign dout      = head_r;

  // Occupancy and storage update; a simultaneous push/pop only occurs at count 1.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      count_r <= 2'd0;
      head_r  <= '0;
      tail_r  <= '0;
    end else begin
      case ({push_ok_s, pop_ok_s})
        2'b10: begin
          if (count_r == 2'd0) begin
            head_r <= din;
          end else begin
            tail_r <= din;
          end
          count_r <= count_r + 2'd1;
        end
        2'b01: begin
          if (count_r == 2'd2) begin
            head_r <= tail_r;
          end
          count_r <= count_r - 2'd1;
        end
        2'b11: begin
          head_r <= din;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extender: ZE/SE/SE_SH2/MOVW over a variable-width field,
// illegal-request flagging with a saturating counter, and a 2-entry output buffer.
module imm_ext_pipe
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 26,
  parameter int OUT_W = 64,
  parameter int WW    = $clog2(IN_W + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  imm_ext_pipe_if.slave bus
);

  logic [IN_W-1:0]      field_s;
  logic                 sign_s;
  logic [OUT_W-1:0]     ze_s;
  logic [OUT_W-1:0]     se_s;
  logic [OUT_W-1:0]     sh2_s;
  logic [OUT_W-1:0]     hw16_s;
  logic [OUT_W-1:0]     movw_s;
  logic [OUT_W-1:0]     ext_s;
  logic [OUT_W-1:0]     result_s;
  logic                 illegal_s;
  logic                 push_s;
  logic                 full_s;
  logic                 empty_s;
  logic [OUT_W:0]       head_s;
  logic [ERR_CNT_W-1:0] err_cnt_r;

  // Mask off bits at/above in_width and pick out the field's top bit.
  always_comb begin
    field_s = '0;
    sign_s  = 1'b0;
    for (int i = 0; i < IN_W; i++) begin
      field_s[i] = bus.in_imm[i] & (i < int'(bus.in_width));
      sign_s     = sign_s | (bus.in_imm[i] & (i + 1 == int'(bus.in_width)));
    end
  end

  assign ze_s   = {{(OUT_W-IN_W){1'b0}}, field_s};
  assign sh2_s  = {se_s[OUT_W-3:0], 2'b00};
  assign hw16_s = {{(OUT_W-16){1'b0}}, bus.in_imm[15:0]};
  assign movw_s = hw16_s << {bus.in_hw, 4'b0000};

  // Sign extension: bits below the field width pass through, the rest copy the sign.
  always_comb begin
    se_s = '0;
    for (int i = 0; i < OUT_W; i++) begin
      se_s[i] = (i < int'(bus.in_width)) ? ze_s[i] : sign_s;
    end
  end

  // Mode select and legality check.
  always_comb begin
    ext_s     = '0;
    illegal_s = 1'b0;
    case (bus.in_mode)
      IMM_ZE: begin
        ext_s     = ze_s;
        illegal_s = (bus.in_width == '0) || (int'(bus.in_width) > IN_W);
      end
      IMM_SE: begin
        ext_s     = se_s;
        illegal_s = (bus.in_width == '0) || (int'(bus.in_width) > IN_W);
      end
      IMM_SE_SH2: begin
        ext_s     = sh2_s;
        illegal_s = (bus.in_width == '0) || (int'(bus.in_width) > IN_W);
      end
      IMM_MOVW: begin
        ext_s     = movw_s;
        illegal_s = (OUT_W == 32) && (bus.in_hw >= 2'd2);
      end
      default: begin
        ext_s     = '0;
        illegal_s = 1'b1;
      end
    endcase
  end

  // Illegal requests still produce an entry, but with zeroed data.
  always_comb begin
    if (illegal_s) begin
      result_s = '0;
    end else begin
      result_s = ext_s;
    end
  end

  assign bus.in_ready = ~full_s & reset_n;
  assign push_s       = bus.in_valid & bus.in_ready;

  imm_ext_fifo2 #(
    .W (OUT_W + 1)
  ) u_fifo (
    .clk   (clk),
    .clr_n (reset_n),
    .push  (push_s),
    .pop   (bus.out_ready),
    .din   ({illegal_s, result_s}),
    .full  (full_s),
    .empty (empty_s),
    .dout  (head_s)
  );

  assign bus.out_valid = ~empty_s;
  assign bus.out_data  = head_s[OUT_W-1:0];
  assign bus.out_err   = head_s[OUT_W];

  // Saturating count of accepted illegal requests.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_r <= '0;
    end else if (push_s && illegal_s && (err_cnt_r != ERR_CNT_MAX)) begin
      err_cnt_r <= err_cnt_r + ERR_CNT_W'(1);
    end
  end

  assign bus.err_count = err_cnt_r;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench for imm_ext_pipe with hand-computed expected results.
module tb_imm_ext_pipe;
  import imm_ext_pkg::*;

  logic clk;
  logic reset_n;
  int   pass_cnt;
  int   total_cnt;

  imm_ext_pipe_if #(.IN_W(26), .OUT_W(64)) bus ();

  imm_ext_pipe #(.IN_W(26), .OUT_W(64)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] mode, input logic [4:0] width,
                       input logic [25:0] imm, input logic [1:0] hw);
    bus.in_valid = 1'b1;
    bus.in_mode  = mode;
    bus.in_width = width;
    bus.in_imm   = imm;
    bus.in_hw    = hw;
  endtask

  // One accepted request with out_ready high; checks the head one edge later.
  task automatic one(input string tag, input logic [2:0] mode, input logic [4:0] width,
                     input logic [25:0] imm, input logic [1:0] hw,
                     input logic [63:0] exp, input logic exp_err);
    drive(mode, width, imm, hw);
    tick();
    bus.in_valid = 1'b0;
    chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
    chk({tag, "_data"}, bus.out_data, exp);
    chk({tag, "_err"}, {63'd0, bus.out_err}, {63'd0, exp_err});
  endtask

  initial begin
    pass_cnt     = 0;
    total_cnt    = 0;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_imm   = 26'd0;
    bus.in_width = 5'd0;
    bus.in_mode  = 3'd0;
    bus.in_hw    = 2'd0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_out_data", bus.out_data, 64'd0);
    chk("rst_out_err", {63'd0, bus.out_err}, 64'd0);
    chk("rst_err_count", {56'd0, bus.err_count}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_in_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();

    // Main function, back-to-back with out_ready high.
    one("ze12", 3'd0, 5'd12, 26'h00001FC, 2'd0, 64'h00000000000001FC, 1'b0);
    one("se12_neg", 3'd1, 5'd12, 26'h0000800, 2'd0, 64'hFFFFFFFFFFFFF800, 1'b0);
    one("se12_garb", 3'd1, 5'd12, 26'h3FFF7FF, 2'd0, 64'h00000000000007FF, 1'b0);
    one("sh2_26", 3'd2, 5'd26, 26'h3FFFFFF, 2'd0, 64'hFFFFFFFFFFFFFFFC, 1'b0);
    one("movw_hw3", 3'd3, 5'd0, 26'h000BEEF, 2'd3, 64'hBEEF000000000000, 1'b0);
    one("movw_hw0", 3'd3, 5'd20, 26'h3FDBEEF, 2'd0, 64'h000000000000BEEF, 1'b0);
    one("ze26", 3'd0, 5'd26, 26'h3FFFFFF, 2'd0, 64'h0000000003FFFFFF, 1'b0);
    one("se1", 3'd1, 5'd1, 26'h0000001, 2'd0, 64'hFFFFFFFFFFFFFFFF, 1'b0);
    tick();
    chk("drain_empty", {63'd0, bus.out_valid}, 64'd0);

    // Backpressure: A, B accepted, C held until space opens.
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd12, 26'h0000111, 2'd0);
    tick();
    chk("bp_a_ready", {63'd0, bus.in_ready}, 64'd1);
    chk("bp_a_head", bus.out_data, 64'h111);
    drive(3'd0, 5'd12, 26'h0000222, 2'd0);
    tick();
    chk("bp_full_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_full_head", bus.out_data, 64'h111);
    drive(3'd0, 5'd12, 26'h0000333, 2'd0);
    tick();
    chk("bp_c_held_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("bp_c_held_head", bus.out_data, 64'h111);
    bus.out_ready = 1'b1;
    tick();
    chk("bp_pop_b", bus.out_data, 64'h222);
    chk("bp_pop_b_ready", {63'd0, bus.in_ready}, 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp_pop_c", bus.out_data, 64'h333);
    chk("bp_pop_c_valid", {63'd0, bus.out_valid}, 64'd1);
    tick();
    chk("bp_no_dup", {63'd0, bus.out_valid}, 64'd0);

    // Illegal requests.
    one("ill_mode5", 3'd5, 5'd12, 26'h0000ABC, 2'd0, 64'd0, 1'b1);
    chk("ill_cnt1", {56'd0, bus.err_count}, 64'd1);
    one("ill_w0", 3'd1, 5'd0, 26'h0000ABC, 2'd0, 64'd0, 1'b1);
    chk("ill_cnt2", {56'd0, bus.err_count}, 64'd2);
    one("ill_w27", 3'd1, 5'd27, 26'h0000ABC, 2'd0, 64'd0, 1'b1);
    chk("ill_cnt3", {56'd0, bus.err_count}, 64'd3);
    tick();

    // Fill the buffer, then reset mid-operation.
    bus.out_ready = 1'b0;
    drive(3'd0, 5'd12, 26'h0000001, 2'd0);
    tick();
    drive(3'd0, 5'd12, 26'h0000002, 2'd0);
    tick();
    bus.in_valid = 1'b0;
    chk("fill_full", {63'd0, bus.in_ready}, 64'd0);
    chk("fill_valid", {63'd0, bus.out_valid}, 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("mid_rst_errcnt", {56'd0, bus.err_count}, 64'd0);
    chk("mid_rst_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("mid_rst_data", bus.out_data, 64'd0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", {63'd0, bus.in_ready}, 64'd1);
    bus.out_ready = 1'b1;
    tick();
    chk("post_rst_no_replay", {63'd0, bus.out_valid}, 64'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
